// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch reads and loader write bursts.
// Bursts lock the port; a starvation counter forces occasional fetch slots into long bursts.
module imem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 16,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              loading,
  output logic [15:0]       ld_count
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  state_t            state, state_next;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] data_hold;
  logic              accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Grants are suppressed while reset is asserted so an abandoned burst writes nothing more.
  always_comb begin
    state_next = state;
    fetch_gnt  = 1'b0;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (ld_valid) begin
            ld_ready  = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
            if (!ld_last) state_next = LOAD;
          end else if (fetch_req) begin
            fetch_gnt = 1'b1;
            mem_addr  = fetch_addr;
          end
        end
        LOAD: begin
          if (fetch_req && starve_cnt == STARVE_LIMIT) begin
            fetch_gnt = 1'b1;
            mem_addr  = fetch_addr;
          end else begin
            ld_ready = 1'b1;
            if (ld_valid) begin
              mem_we    = 1'b1;
              mem_addr  = ld_addr;
              mem_wdata = ld_data;
              if (ld_last) state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign accept  = ld_valid && ld_ready;
  assign loading = (state == LOAD);

  // Counts denied fetch cycles; capped at the limit so the forced-slot compare always hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         starve_cnt <= '0;
    else if (!fetch_req || fetch_gnt) starve_cnt <= '0;
    else if (starve_cnt != STARVE_LIMIT) starve_cnt <= starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    ld_count <= '0;
    else if (accept) begin
      if (state == IDLE)         ld_count <= 16'd1;
      else if (ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
    end
  end

  // Read data arrives the cycle after the grant; it is passed through then and held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_valid <= 1'b0;
      data_hold   <= '0;
    end else begin
      fetch_valid <= fetch_gnt;
      if (fetch_valid) data_hold <= mem_rdata;
    end
  end

  assign fetch_data = fetch_valid ? mem_rdata : data_hold;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_imem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 16;
  localparam int MAX_STARVE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              loading;
  logic [15:0]       ld_count;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .loading(loading), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory array: data for an address appears the following cycle.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  int checks = 0;
  int errors = 0;

  logic              m_in_burst;
  int                m_starve;
  int                m_count;
  logic              m_valid;
  logic [DATA_W-1:0] m_hold;
  logic [DATA_W-1:0] m_pending;
  logic              last_accept;
  logic              last_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_burst = 1'b0;
    m_starve   = 0;
    m_count    = 0;
    m_valid    = 1'b0;
    m_hold     = '0;
    m_pending  = '0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input logic fr, input logic [31:0] fa, input logic lv,
                      input logic [31:0] la, input logic [15:0] ldd, input logic ll);
    logic e_gnt, e_ready, e_we, forced;
    logic [31:0] e_addr;
    logic [15:0] e_wdata, rd;
    fetch_req = fr; fetch_addr = fa; ld_valid = lv; ld_addr = la; ld_data = ldd; ld_last = ll;
    @(negedge clk);
    forced  = m_in_burst && fr && (m_starve == MAX_STARVE);
    e_gnt   = m_in_burst ? forced : (!lv && fr);
    e_ready = m_in_burst ? !forced : lv;
    e_we    = lv && e_ready;
    e_addr  = e_we ? la : (e_gnt ? fa : 32'h0);
    e_wdata = e_we ? ldd : 16'h0;
    rd      = mem[fa[7:0]];
    check("fetch_gnt",   32'(fetch_gnt),   32'(e_gnt));
    check("ld_ready",    32'(ld_ready),    32'(e_ready));
    check("mem_we",      32'(mem_we),      32'(e_we));
    check("mem_addr",    mem_addr,         e_addr);
    check("mem_wdata",   32'(mem_wdata),   32'(e_wdata));
    check("loading",     32'(loading),     32'(m_in_burst));
    check("ld_count",    32'(ld_count),    32'(m_count));
    check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
    check("fetch_data",  32'(fetch_data),  32'(m_valid ? m_pending : m_hold));
    check("starve_cnt",  32'(dut.starve_cnt), 32'(m_starve));
    last_accept = e_we;
    last_gnt    = e_gnt;
    @(posedge clk);
    if (e_we) begin
      if (!m_in_burst) begin
        m_count    = 1;
        m_in_burst = !ll;
      end else begin
        m_count = (m_count == 65535) ? 65535 : m_count + 1;
        if (ll) m_in_burst = 1'b0;
      end
    end
    if (e_gnt || !fr) m_starve = 0;
    else              m_starve = (m_starve >= MAX_STARVE) ? MAX_STARVE : m_starve + 1;
    if (m_valid) m_hold = m_pending;
    m_valid = e_gnt;
    if (e_gnt) m_pending = rd;
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 32'h0, 1'b0, 32'h0, 16'h0, 1'b0);
  endtask

  // Asserts reset asynchronously with the current inputs still applied, then holds it.
  task automatic apply_reset(input int cycles, input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_loading"},  32'(loading),  32'h0);
    check({tag, "_ld_count"}, 32'(ld_count), 32'h0);
    check({tag, "_mem_we"},   32'(mem_we),   32'h0);
    check({tag, "_ld_ready"}, 32'(ld_ready), 32'h0);
    check({tag, "_gnt"},      32'(fetch_gnt), 32'h0);
    fetch_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"},    32'(fetch_valid), 32'h0);
    check({tag, "_fdata"},    32'(fetch_data),  32'h0);
    check({tag, "_addr"},     mem_addr,         32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beat;
    int gnt_mask;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    model_reset();

    // Reset followed by a lone fetch
    #2;
    apply_reset(2, "rst1");
    step(1'b1, 32'h20, 1'b0, 32'h0, 16'h0, 1'b0);
    idle_step();
    idle_step();

    // Six-beat burst with no fetch traffic
    for (int i = 0; i < 6; i++)
      step(1'b0, 32'h0, 1'b1, 32'h20 + i, 16'h0070 + 16'(i), i == 5);
    idle_step();
    check("burst6_count", 32'(ld_count), 32'd6);
    check("burst6_idle",  32'(loading),  32'd0);
    step(1'b1, 32'h21, 1'b0, 32'h0, 16'h0, 1'b0);
    idle_step();

    // Simultaneous requests in IDLE: loader wins, fetch starves one cycle
    step(1'b1, 32'h30, 1'b1, 32'h31, 16'hBEEF, 1'b1);
    check("simul_starve", 32'(dut.starve_cnt), 32'd1);
    step(1'b1, 32'h31, 1'b0, 32'h0, 16'h0, 1'b0);
    idle_step();

    // Ten-beat burst with fetch held throughout: forced slots in cycles 5 and 10
    beat = 0;
    gnt_mask = 0;
    for (int c = 0; c < 40 && beat < 10; c++) begin
      step(1'b1, 32'h80, 1'b1, 32'h40 + beat, 16'h0100 + 16'(beat), beat == 9);
      if (last_gnt) gnt_mask |= (1 << c);
      if (last_accept) beat++;
    end
    check("starve_beats", 32'(beat), 32'd10);
    check("starve_slots", 32'(gnt_mask), 32'((1 << 4) | (1 << 9)));
    idle_step();
    check("starve_count", 32'(ld_count), 32'd10);

    // Reset in the middle of a burst, then a single-beat burst
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 1'b1, 32'h50 + i, 16'h0200 + 16'(i), 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h53; ld_data = 16'h0203;
    apply_reset(1, "rst_mid");
    step(1'b0, 32'h0, 1'b1, 32'h60, 16'h0300, 1'b1);
    idle_step();
    check("single_count", 32'(ld_count), 32'd1);
    check("single_idle",  32'(loading),  32'd0);

    // Bubbles inside a burst
    step(1'b0, 32'h0, 1'b1, 32'h70, 16'h0400, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h71, 16'h0401, 1'b0);
    idle_step();
    idle_step();
    check("bubble_count", 32'(ld_count), 32'd2);
    check("bubble_lock",  32'(loading),  32'd1);
    step(1'b0, 32'h0, 1'b1, 32'h72, 16'h0402, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h73, 16'h0403, 1'b1);
    idle_step();
    check("bubble_final", 32'(ld_count), 32'd4);

    // Random mixed traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255)),
           16'($urandom), ($urandom_range(0, 5) == 0));
    idle_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
